// File: rtl/ahb_pkg.sv
// Shared AHB definitions: slave FSM states, response codes and word-index helpers.
// Bus widths default here when the SoC-level width defines are not supplied.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

package ahb_pkg;
  localparam int AHB_ADDR_W = `AHB_ADDR_WIDTH;
  localparam int AHB_DATA_W = `AHB_DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, WAIT, LAST, ERR1, ERR2} ahb_slv_state_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte address to word index for 32-bit words.
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/ahb_slave_mem_if.sv
// Master/slave view of the AHB signals seen by the memory responder.
interface ahb_slave_mem_if
  import ahb_pkg::*;
#(
  parameter int ADDR_W = AHB_ADDR_W,
  parameter int DATA_W = AHB_DATA_W
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic              haddr_ctrl;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hdata_s2m;
  logic              hready_s2m;
  logic              hresp_s2m;

  modport master (
    output hsel, haddr, haddr_ctrl, hwrite, hwdata,
    input  hdata_s2m, hready_s2m, hresp_s2m
  );

  modport slave (
    input  hsel, haddr, haddr_ctrl, hwrite, hwdata,
    output hdata_s2m, hready_s2m, hresp_s2m
  );
endinterface

// File: rtl/ahb_sram_regfile.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, async clear to zero.
module ahb_sram_regfile #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ahb_slave_mem.sv
// Memory-backed AHB responder with fixed wait states and two-cycle ERROR response.
//   state | meaning
//   IDLE  | no data phase in flight, bus ready
//   WAIT  | OKAY data phase stalled, wcnt_q wait cycles still to go
//   LAST  | final OKAY cycle: read data driven / write committed at closing edge
//   ERR1  | first ERROR cycle, hready low
//   ERR2  | second ERROR cycle, hready high
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int              ADDR_W      = AHB_ADDR_W,
  parameter int              DATA_W      = AHB_DATA_W,
  parameter int              DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rstn,
  ahb_slave_mem_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  ahb_slv_state_t    state_q;
  logic [3:0]        wcnt_q;
  logic [IDX_W-1:0]  addr_q;
  logic              write_q;
  logic              hready_q;
  logic              hresp_q;

  logic              accept;
  logic              addr_err;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] rdata;

  assign accept   = bus.hsel & bus.haddr_ctrl & hready_q;
  assign offset   = bus.haddr - BASE_ADDR;
  assign addr_err = (bus.haddr < BASE_ADDR)
                 || ((offset >> WORD_SHIFT) >= ADDR_W'(DEPTH))
                 || (bus.haddr[WORD_SHIFT-1:0] != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      case (state_q)
        IDLE, LAST, ERR2: begin
          if (accept) begin
            addr_q  <= offset[WORD_SHIFT +: IDX_W];
            write_q <= bus.hwrite;
            if (addr_err) begin
              state_q  <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else if (WAIT_CYCLES == 0) begin
              state_q  <= LAST;
              hready_q <= 1'b1;
              hresp_q  <= HRESP_OKAY;
            end else begin
              state_q  <= WAIT;
              wcnt_q   <= 4'(WAIT_CYCLES - 1);
              hready_q <= 1'b0;
              hresp_q  <= HRESP_OKAY;
            end
          end else begin
            state_q  <= IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
          end
        end
        WAIT: begin
          if (wcnt_q == 4'd0) begin
            state_q  <= LAST;
            hready_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        ERR1: begin
          state_q  <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_ERROR;
        end
        default: begin
          state_q  <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Only LAST ever reaches memory, so faulted transfers never write.
  ahb_sram_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    ((state_q == LAST) && write_q),
    .waddr_i (addr_q),
    .wdata_i (bus.hwdata),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  assign bus.hready_s2m = hready_q;
  assign bus.hresp_s2m  = hresp_q;
  assign bus.hdata_s2m  = ((state_q == LAST) && !write_q) ? rdata : '0;
endmodule
